// File: rtl/table_mem_pkg.sv
// table_mem_pkg: shared types and helpers for the match-table memory responder.
//   table_mem_state_t : responder FSM states
//   TM_WORD_BYTES     : bytes per RAM word
//   helpers           : width mask, byte-lane shifts, split detection
package table_mem_pkg;

  typedef enum logic [2:0] {
    TM_IDLE,
    TM_ACC0,
    TM_ACC1,
    TM_RESP,
    TM_DONE
  } table_mem_state_t;

  localparam int unsigned TM_WORD_BYTES = 4;
  localparam int unsigned TM_DATA_W     = 8 * TM_WORD_BYTES;

  // Legal byte counts are 1..TM_WORD_BYTES.
  function automatic logic tm_width_ok(input logic [3:0] width);
    return (width != 4'd0) && (width <= 4'(TM_WORD_BYTES));
  endfunction

  // One enable bit per requested byte; zero for illegal widths.
  function automatic logic [3:0] tm_width_mask(input logic [3:0] width);
    case (width)
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0011;
      4'd3:    return 4'b0111;
      4'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Width mask expanded to a 32-bit data mask.
  function automatic logic [31:0] tm_byte_mask32(input logic [3:0] width);
    logic [3:0]  m;
    logic [31:0] r;
    m = tm_width_mask(width);
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

  // Byte-enable mask across a word pair: bits [7:4] belong to the second word.
  function automatic logic [7:0] tm_mask_shl(input logic [3:0] width, input logic [1:0] off);
    return {4'b0000, tm_width_mask(width)} << off;
  endfunction

  function automatic logic [63:0] tm_shl_bytes(input logic [63:0] v, input logic [1:0] off);
    return v << {off, 3'b000};
  endfunction

  function automatic logic [63:0] tm_shr_bytes(input logic [63:0] v, input logic [1:0] off);
    return v >> {off, 3'b000};
  endfunction

  // True when the access runs past the end of its first word.
  function automatic logic tm_is_split(input logic [1:0] off, input logic [3:0] width);
    return ({3'b000, off} + {1'b0, width}) > 5'(TM_WORD_BYTES);
  endfunction

endpackage

// File: rtl/table_mem_if.sv
// table_mem_if: matcher-to-table-memory request/response bundle.
//   master : drives ce/we/addr/width/data_i, receives data_o/ready/err
//   slave  : the responder side
interface table_mem_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [3:0]        mem_width_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              mem_ready_o;
  logic              mem_err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
    input  mem_data_o, mem_ready_o, mem_err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
    output mem_data_o, mem_ready_o, mem_err_o
  );
endinterface

// File: rtl/table_mem_bram.sv
// table_mem_bram: single-port synchronous RAM, 32-bit words, byte enables.
//   clk     : clock
//   en_i    : access enable (read always, write when we_i)
//   we_i    : write enable
//   be_i    : byte enables
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, one cycle after en_i; old data on read-during-write
module table_mem_bram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i && be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/table_mem.sv
// table_mem: match-table memory responder. Serves single-beat 1..4 byte reads and
// writes from an internal RAM and completes each with a one-cycle ready pulse.
//   clk, rst : clock, synchronous active-high reset
//   mem      : table_mem_if.slave request/response bundle
// Optional: TABLE_MEM_UNALIGNED_EN enables word-crossing accesses (split via ACC1);
// without it such accesses complete with an error.
module table_mem
  import table_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  table_mem_if.slave    mem
);

  localparam int unsigned WA_W   = ADDR_W - 2;
  localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  table_mem_state_t state_q;

  logic              we_q;
  logic [3:0]        width_q;
  logic [1:0]        off_q;
  logic              err_q;
  logic [RAM_AW-1:0] wa0_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              rerr_q;
  logic [31:0]       rdata_q;
  logic [31:0]       resp_data_d;

  // Request decode on the live bus, used only in IDLE.
  logic [WA_W-1:0] req_wa0;
  logic [1:0]      req_off;
  logic            req_split;
  logic            req_err;

  assign req_wa0   = mem.mem_addr_i[ADDR_W-1:2];
  assign req_off   = mem.mem_addr_i[1:0];
  assign req_split = tm_is_split(req_off, mem.mem_width_i);

`ifdef TABLE_MEM_UNALIGNED_EN
  logic [WA_W:0] req_wa1;
  logic          split_q;
  logic [31:0]   word0_q;

  assign req_wa1 = {1'b0, req_wa0} + (WA_W+1)'(1);
  assign req_err = !tm_width_ok(mem.mem_width_i)
                || (32'(req_wa0) >= DEPTH_WORDS)
                || (req_split && (32'(req_wa1) >= DEPTH_WORDS));
`else
  assign req_err = !tm_width_ok(mem.mem_width_i)
                || (32'(req_wa0) >= DEPTH_WORDS)
                || req_split;
`endif

  // RAM port drive; reset suppresses any access in the reset cycle.
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = wa0_q;
    ram_wdata = 32'(tm_shl_bytes({32'b0, wdata_q}, off_q));
    if (!rst) begin
      case (state_q)
        TM_ACC0: begin
          ram_en = 1'b1;
          ram_we = we_q;
          ram_be = 4'(tm_mask_shl(width_q, off_q));
        end
`ifdef TABLE_MEM_UNALIGNED_EN
        TM_ACC1: begin
          ram_en    = 1'b1;
          ram_we    = we_q;
          ram_addr  = wa0_q + RAM_AW'(1);
          ram_be    = 4'(tm_mask_shl(width_q, off_q) >> 4);
          ram_wdata = 32'(tm_shl_bytes({32'b0, wdata_q}, off_q) >> 32);
        end
`endif
        default: ;
      endcase
    end
  end

  table_mem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (RAM_AW)
  ) u_bram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Read assembly: align {word1, word0} to the byte offset, keep width bytes.
  logic [63:0] rd_pair;

  always_comb begin
`ifdef TABLE_MEM_UNALIGNED_EN
    rd_pair = split_q ? {ram_rdata, word0_q} : {32'b0, ram_rdata};
`else
    rd_pair = {32'b0, ram_rdata};
`endif
    resp_data_d = 32'b0;
    if (!err_q && !we_q) begin
      resp_data_d = 32'(tm_shr_bytes(rd_pair, off_q)) & tm_byte_mask32(width_q);
    end
  end

  // Responder FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TM_IDLE;
      ready_q <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      case (state_q)
        TM_IDLE: begin
          if (mem.mem_ce_i) begin
            we_q    <= mem.mem_we_i;
            width_q <= mem.mem_width_i;
            off_q   <= req_off;
            err_q   <= req_err;
            wa0_q   <= RAM_AW'(req_wa0);
            wdata_q <= mem.mem_data_i;
`ifdef TABLE_MEM_UNALIGNED_EN
            split_q <= req_split;
`endif
            state_q <= req_err ? TM_RESP : TM_ACC0;
          end
        end
        TM_ACC0: begin
`ifdef TABLE_MEM_UNALIGNED_EN
          state_q <= split_q ? TM_ACC1 : TM_RESP;
`else
          state_q <= TM_RESP;
`endif
        end
`ifdef TABLE_MEM_UNALIGNED_EN
        TM_ACC1: begin
          word0_q <= ram_rdata;
          state_q <= TM_RESP;
        end
`endif
        TM_RESP: begin
          rdata_q <= resp_data_d;
          rerr_q  <= err_q;
          ready_q <= 1'b1;
          state_q <= TM_DONE;
        end
        TM_DONE: begin
          // Request bus is ignored here; a still-high ce is taken as new in IDLE.
          ready_q <= 1'b0;
          rerr_q  <= 1'b0;
          rdata_q <= 32'b0;
          state_q <= TM_IDLE;
        end
        default: state_q <= TM_IDLE;
      endcase
    end
  end

  assign mem.mem_ready_o = ready_q;
  assign mem.mem_err_o   = rerr_q;
  assign mem.mem_data_o  = rdata_q;

endmodule

// File: tb/tb_table_mem.sv
// tb_table_mem: directed, table-driven bench for table_mem plus hand-written
// sequences for held ce, reset mid-request and reset during a split write.
// Expectations follow TABLE_MEM_UNALIGNED_EN when it is defined.
module tb_table_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  table_mem_if #(.ADDR_W(16)) ifc ();

  table_mem #(
    .ADDR_W      (16),
    .DEPTH_WORDS (4096)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (ifc)
  );

`ifdef TABLE_MEM_UNALIGNED_EN
  localparam logic [31:0] EXP_W10  = 32'h34CCBBAA;
  localparam logic [31:0] EXP_R11  = 32'h0034CCBB;
`else
  localparam logic [31:0] EXP_W10  = 32'hDDCCBBAA;
  localparam logic [31:0] EXP_R11  = 32'h00DDCCBB;
`endif

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  width;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [15:0] addr, input logic [3:0] width,
                     input logic [31:0] wdata, input logic [31:0] exp_data,
                     input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.width = width; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vq.push_back(v);
  endtask

  // Issue one request from an IDLE cycle; returns cycle of ready (-1 on timeout).
  task automatic run_req(input logic we, input logic [15:0] addr, input logic [3:0] width,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic err, output int lat, output logic ready_after);
    ifc.mem_we_i    = we;
    ifc.mem_addr_i  = addr;
    ifc.mem_width_i = width;
    ifc.mem_data_i  = wdata;
    ifc.mem_ce_i    = 1'b1;
    lat = -1; rd = 32'b0; err = 1'b0; ready_after = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ifc.mem_ready_o) begin
        lat = c;
        rd  = ifc.mem_data_o;
        err = ifc.mem_err_o;
        break;
      end
    end
    ifc.mem_ce_i = 1'b0;
    @(posedge clk); #1;
    ready_after = ifc.mem_ready_o;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        rdy_after;
    logic [8:1]  pat;
    logic        seen;

    rst = 1'b1;
    ifc.mem_ce_i = 1'b0; ifc.mem_we_i = 1'b0; ifc.mem_addr_i = '0;
    ifc.mem_width_i = 4'd0; ifc.mem_data_i = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ifc.mem_ready_o), 32'd0);
    chk("reset_err",   32'(ifc.mem_err_o),   32'd0);
    chk("reset_data",  ifc.mem_data_o,       32'd0);
    rst = 1'b0;

    //   we    addr      w     wdata          exp_data       err lat
    add(1'b1, 16'h0010, 4'd4, 32'hDDCCBBAA, 32'h00000000, 1'b0, 3);
    add(1'b0, 16'h0010, 4'd4, 32'h0,        32'hDDCCBBAA, 1'b0, 3);
    add(1'b0, 16'h0012, 4'd1, 32'h0,        32'h000000CC, 1'b0, 3);
`ifdef TABLE_MEM_UNALIGNED_EN
    add(1'b1, 16'h0013, 4'd2, 32'h00001234, 32'h00000000, 1'b0, 4);
    add(1'b0, 16'h0010, 4'd4, 32'h0,        32'h34CCBBAA, 1'b0, 3);
    add(1'b0, 16'h0014, 4'd1, 32'h0,        32'h00000012, 1'b0, 3);
    add(1'b0, 16'h0013, 4'd2, 32'h0,        32'h00001234, 1'b0, 4);
`else
    add(1'b1, 16'h0013, 4'd2, 32'h00001234, 32'h00000000, 1'b1, 2);
    add(1'b0, 16'h0010, 4'd4, 32'h0,        32'hDDCCBBAA, 1'b0, 3);
    add(1'b0, 16'h0013, 4'd2, 32'h0,        32'h00000000, 1'b1, 2);
`endif
    add(1'b0, 16'h0011, 4'd3, 32'h0,        EXP_R11,      1'b0, 3);
    add(1'b1, 16'h0010, 4'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2);
    add(1'b1, 16'h0010, 4'd5, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2);
    add(1'b1, 16'h4000, 4'd4, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2);
    add(1'b0, 16'h4000, 4'd1, 32'h0,        32'h00000000, 1'b1, 2);
    add(1'b0, 16'h0010, 4'd4, 32'h0,        EXP_W10,      1'b0, 3);
    add(1'b1, 16'h3FFC, 4'd4, 32'h11223344, 32'h00000000, 1'b0, 3);
    add(1'b0, 16'h3FFF, 4'd1, 32'h0,        32'h00000011, 1'b0, 3);
    add(1'b0, 16'h3FFE, 4'd4, 32'h0,        32'h00000000, 1'b1, 2);
    add(1'b1, 16'h0020, 4'd4, 32'h00000000, 32'h00000000, 1'b0, 3);
    add(1'b1, 16'h0021, 4'd1, 32'hAABBCC55, 32'h00000000, 1'b0, 3);
    add(1'b0, 16'h0020, 4'd4, 32'h0,        32'h00005500, 1'b0, 3);

    foreach (vq[i]) begin
      run_req(vq[i].we, vq[i].addr, vq[i].width, vq[i].wdata, rd, err, lat, rdy_after);
      chk($sformatf("v%0d_lat", i),   32'(lat),       32'(vq[i].exp_lat));
      chk($sformatf("v%0d_data", i),  rd,             vq[i].exp_data);
      chk($sformatf("v%0d_err", i),   32'(err),       32'(vq[i].exp_err));
      chk($sformatf("v%0d_pulse", i), 32'(rdy_after), 32'd0);
    end

    // ce held high through DONE: one pulse per accepted request, at cycles 3 and 7.
    ifc.mem_we_i = 1'b0; ifc.mem_addr_i = 16'h0010; ifc.mem_width_i = 4'd4;
    ifc.mem_ce_i = 1'b1;
    rd = 32'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      pat[c] = ifc.mem_ready_o;
      if (c == 7) begin
        rd = ifc.mem_data_o;
        ifc.mem_ce_i = 1'b0;
      end
    end
    chk("hold_ce_pattern", 32'(pat), 32'h00000044);
    chk("hold_ce_data2",   rd,       EXP_W10);

    // Reset in the middle of a request: no pulse, outputs cleared.
`ifdef TABLE_MEM_UNALIGNED_EN
    ifc.mem_we_i = 1'b0; ifc.mem_addr_i = 16'h0013; ifc.mem_width_i = 4'd2;
    ifc.mem_ce_i = 1'b1;
    repeat (2) @(posedge clk);
`else
    ifc.mem_we_i = 1'b0; ifc.mem_addr_i = 16'h0010; ifc.mem_width_i = 4'd4;
    ifc.mem_ce_i = 1'b1;
    repeat (1) @(posedge clk);
`endif
    #1;
    rst = 1'b1;
    ifc.mem_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 32'(ifc.mem_ready_o), 32'd0);
    chk("midrst_err",   32'(ifc.mem_err_o),   32'd0);
    chk("midrst_data",  ifc.mem_data_o,       32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | ifc.mem_ready_o;
    end
    chk("midrst_no_pulse", 32'(seen), 32'd0);
    run_req(1'b0, 16'h0010, 4'd4, 32'h0, rd, err, lat, rdy_after);
    chk("postrst_lat",  32'(lat), 32'd3);
    chk("postrst_data", rd,       EXP_W10);
    chk("postrst_err",  32'(err), 32'd0);

`ifdef TABLE_MEM_UNALIGNED_EN
    // Reset during ACC1 of a split write: word 0 byte kept, word 1 byte never written.
    run_req(1'b1, 16'h0018, 4'd4, 32'h00000000, rd, err, lat, rdy_after);
    chk("clr18_lat", 32'(lat), 32'd3);
    ifc.mem_we_i = 1'b1; ifc.mem_addr_i = 16'h0017; ifc.mem_width_i = 4'd2;
    ifc.mem_data_i = 32'h0000EEFF;
    ifc.mem_ce_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.mem_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_req(1'b0, 16'h0017, 4'd1, 32'h0, rd, err, lat, rdy_after);
    chk("wrst_word0_kept", rd, 32'h000000FF);
    run_req(1'b0, 16'h0018, 4'd1, 32'h0, rd, err, lat, rdy_after);
    chk("wrst_word1_untouched", rd, 32'h00000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
